if_id_stage: RTL and testbench
==============================

Name: if_id_stage

Overview:
Parametrised IF/ID pipeline stage for the core. It registers the fetched instruction and PC, extracts the register indices, and generates the RV32I immediate, sign-extended to WordSize. Both sides use a valid/ready handshake, with a 2-entry skid buffer so that in_ready is driven from a register. Flush support covers branch redirects; stall is expressed through out_ready.

Parameters:
WordSize, 32, datapath/PC/immediate width; legal values ≥ 32
ResetPc, 0, value driven on pc while the stage is empty after reset

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  fetch presents an instruction
in_ready  output  1  stage can accept; registered (low only when the skid entry is occupied)
ins  input  32  instruction word
pc_in  input  WordSize  PC of ins
immode  input  3  immediate format: 0 none, 1 I, 2 S, 3 B, 4 U, 5 J, 6 shamt, 7 reserved
flush  input  1  discard all held and incoming entries
out_valid  output  1  decode outputs valid
out_ready  input  1  decode consumes the head entry
rdn  output  5  ins[11:7] of the head entry
rs1n  output  5  ins[19:15] of the head entry
rs2n  output  5  ins[24:20] of the head entry
imm  output  WordSize  generated immediate of the head entry
pc  output  WordSize  PC of the head entry
ins_out  output  32  raw instruction of the head entry

Behaviour:
- Storage: a head register (drives outputs) and a skid register. Each holds {ins, pc, imm, valid}. imm is computed on enqueue and stored.
- Transfers: an input transfer occurs when in_valid & in_ready; an output transfer occurs when out_valid & out_ready.
- Latency: an entry accepted in cycle N while the stage is empty appears with out_valid=1 in cycle N+1.
- Same-cycle push and pop with only the head valid: the new entry replaces the head. The skid stays empty and throughput is 1 per cycle.
- Push while the head is held (out_ready=0): the entry goes to the skid; in_ready drops the next cycle.
- Pop with the skid valid: the skid moves to the head and in_ready rises the next cycle. No push can occur that cycle, because in_ready=0.
- Order is strictly FIFO; no entry is dropped or duplicated except on flush.
- Flush: both valids clear at the edge and an incoming transfer in the same cycle is discarded. The cycle after, out_valid=0 and in_ready=1. If rst and flush are both asserted, rst applies.
- Reset values: out_valid=0, in_ready=1, rdn=rs1n=rs2n=0, imm=0, ins_out=0, pc=ResetPc, skid empty.
  - The same reset takes effect mid-transfer; any in-flight handshake is discarded.
- Payload when out_valid=0: the last popped payload is held. Verification must not check payload while out_valid=0.
- Immediate generation; S(x) means sign-extend x to WordSize:
  - 1 I: S(ins[31:20])
  - 2 S: S({ins[31:25], ins[11:7]})
  - 3 B: S({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0})
  - 4 U: S({ins[31:12], 12'b0})
  - 5 J: S({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0})
  - 6 shamt: zero-extended ins[24:20]
  - 0 and 7: 0
- Register indices are extracted regardless of immode.

Test Plan:
- Reset, then idle → out_valid=0, in_ready=1, pc=ResetPc, imm=0.
- Push ins=0xFFF00093, immode=1, pc_in=0x100, out_ready=1 → next cycle out_valid=1, rdn=1, rs1n=0, imm=0xFFFFFFFF, pc=0x100.
- Back-to-back B then J with out_ready=1:
  - ins=0xFE000EE3, immode=3 → imm=0xFFFFFFFC
  - ins=0xFF9FF06F, immode=5 → imm=0xFFFFFFF8
  - one output per cycle, in order.
- out_ready=0 while pushing A, B, C → A at head, B in skid, in_ready=0 from the cycle after B. C is not accepted until out_ready=1, then A, B, C emerge in order with no loss.
- Full buffer plus flush with in_valid=1 → next cycle out_valid=0, in_ready=1, and the incoming entry is absent from the outputs.
- Assert rst while the skid is full and out_ready=1 → all reset values next cycle. Repeat the reset-idle, I-type and B/J-pair scenarios with WordSize=64: imm for ins=0xFFF00093 is 0xFFFFFFFFFFFFFFFF.

Source files
------------

// File: rtl/if_id_stage.sv
// IF/ID pipeline stage: registers fetched instruction and PC, decodes register
// indices and the RV32I immediate, with a 2-entry skid buffer behind valid/ready.
module if_id_stage #(
    parameter int unsigned         WordSize = 32,
    parameter logic [WordSize-1:0] ResetPc  = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [31:0]         ins,
    input  logic [WordSize-1:0] pc_in,
    input  logic [2:0]          immode,
    input  logic                flush,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [4:0]          rdn,
    output logic [4:0]          rs1n,
    output logic [4:0]          rs2n,
    output logic [WordSize-1:0] imm,
    output logic [WordSize-1:0] pc,
    output logic [31:0]         ins_out
);

    typedef struct packed {
        logic [31:0]         ins;
        logic [WordSize-1:0] pc;
        logic [WordSize-1:0] imm;
    } entry_t;

    // Immediate formats; the size casts of signed operands perform the sign extension.
    function automatic logic [WordSize-1:0] gen_imm(input logic [31:0] i_w, input logic [2:0] mode);
        logic [WordSize-1:0] v;
        case (mode)
            3'd1:    v = WordSize'($signed(i_w[31:20]));
            3'd2:    v = WordSize'($signed({i_w[31:25], i_w[11:7]}));
            3'd3:    v = WordSize'($signed({i_w[31], i_w[7], i_w[30:25], i_w[11:8], 1'b0}));
            3'd4:    v = WordSize'($signed({i_w[31:12], 12'b0}));
            3'd5:    v = WordSize'($signed({i_w[31], i_w[19:12], i_w[20], i_w[30:21], 1'b0}));
            3'd6:    v = WordSize'(i_w[24:20]);
            default: v = '0;
        endcase
        return v;
    endfunction

    entry_t r_head;
    entry_t r_skid;
    logic   r_head_valid;
    logic   r_skid_valid;
    logic   r_in_ready;

    entry_t w_new;
    entry_t w_head_n;
    entry_t w_skid_n;
    logic   w_head_valid_n;
    logic   w_skid_valid_n;
    logic   w_push;
    logic   w_pop;

    assign w_push    = in_valid & r_in_ready;
    assign w_pop     = r_head_valid & out_ready;
    assign w_new.ins = ins;
    assign w_new.pc  = pc_in;
    assign w_new.imm = gen_imm(ins, immode);

    // Next-state for head/skid; r_in_ready is low exactly while the skid is full,
    // so a push and a skid refill can never coincide.
    always_comb begin
        w_head_n       = r_head;
        w_skid_n       = r_skid;
        w_head_valid_n = r_head_valid;
        w_skid_valid_n = r_skid_valid;
        if (flush) begin
            w_head_valid_n = 1'b0;
            w_skid_valid_n = 1'b0;
        end else if (r_skid_valid) begin
            if (w_pop) begin
                w_head_n       = r_skid;
                w_skid_valid_n = 1'b0;
            end
        end else if (w_push) begin
            if (!r_head_valid || w_pop) begin
                w_head_n       = w_new;
                w_head_valid_n = 1'b1;
            end else begin
                w_skid_n       = w_new;
                w_skid_valid_n = 1'b1;
            end
        end else if (w_pop) begin
            w_head_valid_n = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head       <= '{ins: 32'd0, pc: ResetPc, imm: '0};
            r_skid       <= '0;
            r_head_valid <= 1'b0;
            r_skid_valid <= 1'b0;
            r_in_ready   <= 1'b1;
        end else begin
            r_head       <= w_head_n;
            r_skid       <= w_skid_n;
            r_head_valid <= w_head_valid_n;
            r_skid_valid <= w_skid_valid_n;
            r_in_ready   <= !w_skid_valid_n;
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_head_valid;
    assign ins_out   = r_head.ins;
    assign pc        = r_head.pc;
    assign imm       = r_head.imm;
    assign rdn       = r_head.ins[11:7];
    assign rs1n      = r_head.ins[19:15];
    assign rs2n      = r_head.ins[24:20];

endmodule

// File: tb/tb_if_id_stage.sv
// Bench for if_id_stage: 32- and 64-bit instances share stimulus and are checked
// against a queue model of held entries plus a hand-computed immediate table.
module tb_if_id_stage;

    localparam logic [31:0] RPC32 = 32'h0000_0080;
    localparam logic [63:0] RPC64 = 64'h0000_0001_0000_1000;

    logic        clk = 1'b0;
    logic        rst, in_valid, flush, out_ready;
    logic [31:0] ins;
    logic [63:0] pc_in;
    logic [2:0]  immode;
    logic [63:0] cur_imm;

    logic        a_in_ready, a_out_valid, b_in_ready, b_out_valid;
    logic [4:0]  a_rdn, a_rs1n, a_rs2n, b_rdn, b_rs1n, b_rs2n;
    logic [31:0] a_imm, a_pc, a_ins_out, b_ins_out;
    logic [63:0] b_imm, b_pc;

    always #5 clk = ~clk;

    if_id_stage #(.WordSize(32), .ResetPc(RPC32)) u_dut32 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready), .ins(ins),
        .pc_in(pc_in[31:0]), .immode(immode), .flush(flush), .out_valid(a_out_valid),
        .out_ready(out_ready), .rdn(a_rdn), .rs1n(a_rs1n), .rs2n(a_rs2n), .imm(a_imm),
        .pc(a_pc), .ins_out(a_ins_out));

    if_id_stage #(.WordSize(64), .ResetPc(RPC64)) u_dut64 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready), .ins(ins),
        .pc_in(pc_in), .immode(immode), .flush(flush), .out_valid(b_out_valid),
        .out_ready(out_ready), .rdn(b_rdn), .rs1n(b_rs1n), .rs2n(b_rs2n), .imm(b_imm),
        .pc(b_pc), .ins_out(b_ins_out));

    typedef struct { logic [31:0] ins; logic [63:0] pc; logic [63:0] imm; } exp_t;
    typedef struct { logic [31:0] ins; logic [2:0] mode; logic [63:0] imm; } vec_t;

    exp_t sb[$];
    vec_t vt[15];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cmp_payload(input exp_t e);
        check("ins_out32", 64'(a_ins_out), 64'(e.ins));
        check("pc32",      64'(a_pc),      64'(e.pc[31:0]));
        check("imm32",     64'(a_imm),     64'(e.imm[31:0]));
        check("rdn32",     64'(a_rdn),     64'(e.ins[11:7]));
        check("rs1n32",    64'(a_rs1n),    64'(e.ins[19:15]));
        check("rs2n32",    64'(a_rs2n),    64'(e.ins[24:20]));
        check("ins_out64", 64'(b_ins_out), 64'(e.ins));
        check("pc64",      b_pc,           e.pc);
        check("imm64",     b_imm,          e.imm);
        check("rdn64",     64'(b_rdn),     64'(e.ins[11:7]));
        check("rs1n64",    64'(b_rs1n),    64'(e.ins[19:15]));
        check("rs2n64",    64'(b_rs2n),    64'(e.ins[24:20]));
    endtask

    task automatic check_reset();
        check("rst_out_valid32", 64'(a_out_valid), 64'd0);
        check("rst_in_ready32",  64'(a_in_ready),  64'd1);
        check("rst_pc32",        64'(a_pc),        64'(RPC32));
        check("rst_imm32",       64'(a_imm),       64'd0);
        check("rst_regs32",      64'({a_rdn, a_rs1n, a_rs2n}), 64'd0);
        check("rst_ins32",       64'(a_ins_out),   64'd0);
        check("rst_out_valid64", 64'(b_out_valid), 64'd0);
        check("rst_in_ready64",  64'(b_in_ready),  64'd1);
        check("rst_pc64",        b_pc,             RPC64);
        check("rst_imm64",       b_imm,            64'd0);
        check("rst_regs64",      64'({b_rdn, b_rs1n, b_rs2n}), 64'd0);
        check("rst_ins64",       64'(b_ins_out),   64'd0);
    endtask

    // One clock: check handshake state against the model, retire/accept, advance.
    task automatic tick();
        exp_t e;
        bit   can_push;
        can_push = (sb.size() < 2);
        check("out_valid32", 64'(a_out_valid), 64'(sb.size() > 0));
        check("in_ready32",  64'(a_in_ready),  64'(can_push));
        check("out_valid64", 64'(b_out_valid), 64'(sb.size() > 0));
        check("in_ready64",  64'(b_in_ready),  64'(can_push));
        if (sb.size() > 0 && out_ready) begin
            e = sb.pop_front();
            cmp_payload(e);
        end
        if (rst || flush) sb.delete();
        else if (in_valid && can_push) sb.push_back('{ins: ins, pc: pc_in, imm: cur_imm});
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_in(input vec_t v, input logic [63:0] p);
        in_valid = 1'b1;
        ins      = v.ins;
        immode   = v.mode;
        cur_imm  = v.imm;
        pc_in    = p;
    endtask

    // Present v until the model says it was accepted (bounded).
    task automatic push_wait(input vec_t v, input logic [63:0] p);
        bit acc;
        set_in(v, p);
        for (int k = 0; k < 20; k++) begin
            acc = (sb.size() < 2) && !flush && !rst;
            tick();
            if (acc) begin
                in_valid = 1'b0;
                return;
            end
        end
        check("push_timeout", 64'd0, 64'd1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int k = 0; k < 10 && sb.size() > 0; k++) tick();
        check("drain_empty", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        vt[0]  = '{32'hFFF00093, 3'd1, 64'hFFFF_FFFF_FFFF_FFFF};
        vt[1]  = '{32'hFE000EE3, 3'd3, 64'hFFFF_FFFF_FFFF_FFFC};
        vt[2]  = '{32'hFF9FF06F, 3'd5, 64'hFFFF_FFFF_FFFF_FFF8};
        vt[3]  = '{32'h7FF00093, 3'd1, 64'h0000_0000_0000_07FF};
        vt[4]  = '{32'hFE512E23, 3'd2, 64'hFFFF_FFFF_FFFF_FFFC};
        vt[5]  = '{32'h00000463, 3'd3, 64'h0000_0000_0000_0008};
        vt[6]  = '{32'h0080006F, 3'd5, 64'h0000_0000_0000_0008};
        vt[7]  = '{32'h12345037, 3'd4, 64'h0000_0000_1234_5000};
        vt[8]  = '{32'h800002B7, 3'd4, 64'hFFFF_FFFF_8000_0000};
        vt[9]  = '{32'h01F09093, 3'd6, 64'h0000_0000_0000_001F};
        vt[10] = '{32'hFFFFFFFF, 3'd6, 64'h0000_0000_0000_001F};
        vt[11] = '{32'hFFFFFFFF, 3'd0, 64'h0000_0000_0000_0000};
        vt[12] = '{32'hFFFFFFFF, 3'd7, 64'h0000_0000_0000_0000};
        vt[13] = '{32'hA5A5A5A5, 3'd2, 64'hFFFF_FFFF_FFFF_FA4B};
        vt[14] = '{32'h80000013, 3'd1, 64'hFFFF_FFFF_FFFF_F800};

        rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        ins = '0; pc_in = '0; immode = '0; cur_imm = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check_reset();
        repeat (2) tick();

        // Streaming at full rate through the immediate table.
        out_ready = 1'b1;
        for (int i = 0; i < 15; i++) push_wait(vt[i], 64'hA5A5_0000_0000_0100 + 64'(4 * i));
        drain();

        // Stall: A at head, B in skid, C held off until out_ready returns.
        out_ready = 1'b0;
        push_wait(vt[3], 64'h200);
        push_wait(vt[4], 64'h204);
        check("stall_in_ready32", 64'(a_in_ready), 64'd0);
        set_in(vt[5], 64'h208);
        repeat (3) tick();
        out_ready = 1'b1;
        push_wait(vt[5], 64'h208);
        drain();

        // Flush with a full buffer and an incoming entry in the same cycle.
        out_ready = 1'b0;
        push_wait(vt[7], 64'h300);
        push_wait(vt[8], 64'h304);
        set_in(vt[9], 64'h308);
        flush = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        check("flush_out_valid32", 64'(a_out_valid), 64'd0);
        check("flush_in_ready64",  64'(b_in_ready),  64'd1);
        out_ready = 1'b1;
        repeat (3) tick();

        // Reset while the skid is full and decode is ready.
        out_ready = 1'b0;
        push_wait(vt[0], 64'h400);
        push_wait(vt[1], 64'h404);
        out_ready = 1'b1;
        set_in(vt[2], 64'h408);
        rst = 1'b1;
        tick();
        rst = 1'b0; in_valid = 1'b0;
        check_reset();
        repeat (2) tick();

        // Stage still works after reset.
        push_wait(vt[0], 64'h500);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
